god_bless_apollo_pll_reset_seq: RTL and testbench

//  Sequences the 50 MHz -> 25/200 MHz system PLL and owns all downstream resets.
//  - Pulses PLL reset and waits for a stable lock.
//  - Releases per-clock-domain resets in a fixed staggered order.
//  - On lock loss, re-asserts domain resets and relocks.
//  - Retries failed lock attempts, then flags a hard failure.

---
 rtl/god_bless_apollo_pll_reset_seq.sv | 163 ++++++++++++++++
 tb/tb_god_bless_apollo_pll_reset_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/god_bless_apollo_pll_reset_seq.sv
// PLL bring-up and staggered domain-reset sequencer; all outputs registered, decisions on synced lock.
// Optional LOCK_LOSS_COUNT_EN adds a saturating lock_loss_cnt_o counter of RUN/RELEASE lock losses.
module god_bless_apollo_pll_reset_seq #(
   parameter int PLL_RST_CYCLES = 8,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int STAGGER        = 16,
   parameter int NUM_DOMAINS    = 2,
   parameter int MAX_RETRIES    = 4
) (
   input  logic                   refclk,
   input  logic                   rst,
   input  logic                   soft_rst_i,
   input  logic                   pll_locked_i,
   output logic                   pll_rst_o,
   output logic [NUM_DOMAINS-1:0] dom_rst_o,
   output logic                   ready_o,
   output logic                   fail_o,
   output logic [3:0]             retry_cnt_o
`ifdef LOCK_LOSS_COUNT_EN
   ,
   output logic [7:0]             lock_loss_cnt_o
`endif
);

   localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CD  = (STABLE_CYCLES > STAGGER) ? STABLE_CYCLES : STAGGER;
   localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW      = $clog2(MAX_ALL) + 1;

   localparam logic [CW-1:0] PLL_LAST     = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER - 1);
   localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_RELEASE, S_RUN, S_FAIL
   } state_t;

   state_t                  state, state_nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [3:0]              retry_nxt;
   logic [1:0]              sync_q;
   logic                    locked_s;
   logic                    step;
   logic                    pll_rst_nxt, ready_nxt, fail_nxt;
   logic [NUM_DOMAINS-1:0]  dom_nxt;

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) sync_q <= 2'b00;
      else     sync_q <= {sync_q[0], pll_locked_i};
   end
   assign locked_s = sync_q[1];

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state       <= S_PLL_RST;
         cnt         <= '0;
         retry_cnt_o <= '0;
         pll_rst_o   <= 1'b1;
         dom_rst_o   <= '1;
         ready_o     <= 1'b0;
         fail_o      <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         retry_cnt_o <= retry_nxt;
         pll_rst_o   <= pll_rst_nxt;
         dom_rst_o   <= dom_nxt;
         ready_o     <= ready_nxt;
         fail_o      <= fail_nxt;
      end
   end

   // step marks an edge on which the lowest still-asserted domain reset is released
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      retry_nxt = retry_cnt_o;
      step      = 1'b0;
      if (soft_rst_i) begin
         state_nxt = S_PLL_RST;
         cnt_nxt   = '0;
         retry_nxt = '0;
      end else begin
         case (state)
            S_PLL_RST: begin
               if (cnt == PLL_LAST) begin
                  state_nxt = S_WAIT_LOCK;
                  cnt_nxt   = '0;
               end else cnt_nxt = cnt + 1'b1;
            end
            S_WAIT_LOCK: begin
               if (locked_s) begin
                  state_nxt = S_STABLE;
                  cnt_nxt   = CW'(1);
               end else if (cnt == TIMEOUT_LAST) begin
                  retry_nxt = retry_cnt_o + 4'd1;
                  cnt_nxt   = '0;
                  state_nxt = (retry_nxt == RETRY_LIMIT) ? S_FAIL : S_PLL_RST;
               end else cnt_nxt = cnt + 1'b1;
            end
            S_STABLE: begin
               if (!locked_s) begin
                  state_nxt = S_WAIT_LOCK;
                  cnt_nxt   = '0;
               end else if (cnt >= STABLE_LAST) begin
                  state_nxt = S_RELEASE;
                  cnt_nxt   = '0;
                  step      = 1'b1;
               end else cnt_nxt = cnt + 1'b1;
            end
            S_RELEASE: begin
               if (!locked_s) begin
                  state_nxt = S_PLL_RST;
                  cnt_nxt   = '0;
               end else if (dom_rst_o == '0) begin
                  state_nxt = S_RUN;
                  retry_nxt = '0;
               end else if (cnt == STAGGER_LAST) begin
                  cnt_nxt = '0;
                  step    = 1'b1;
               end else cnt_nxt = cnt + 1'b1;
            end
            S_RUN: begin
               if (!locked_s) begin
                  state_nxt = S_PLL_RST;
                  cnt_nxt   = '0;
               end
            end
            S_FAIL: ;
            default: begin
               state_nxt = S_PLL_RST;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Asserted resets form a contiguous run at the top, so a left shift releases the lowest one
   always_comb begin
      pll_rst_nxt = (state_nxt == S_PLL_RST) || (state_nxt == S_FAIL);
      ready_nxt   = (state_nxt == S_RUN);
      fail_nxt    = (state_nxt == S_FAIL);
      case (state_nxt)
         S_RELEASE: dom_nxt = step ? (dom_rst_o << 1) : dom_rst_o;
         S_RUN:     dom_nxt = dom_rst_o;
         default:   dom_nxt = '1;
      endcase
   end

`ifdef LOCK_LOSS_COUNT_EN
   logic loss;
   assign loss = !soft_rst_i && !locked_s && ((state == S_RELEASE) || (state == S_RUN));

   always_ff @(posedge refclk or posedge rst) begin
      if (rst)                               lock_loss_cnt_o <= 8'd0;
      else if (loss && lock_loss_cnt_o != 8'hFF) lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
   end
`endif

endmodule

// File: tb/tb_god_bless_apollo_pll_reset_seq.sv
// Scoreboard bench: each scenario queues time-stamped expected output vectors and checks them as edges pass.
module tb_god_bless_apollo_pll_reset_seq;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       soft_rst_i = 1'b0;
   logic       pll_locked_i = 1'b0;
   logic       pll_rst_o;
   logic [1:0] dom_rst_o;
   logic       ready_o;
   logic       fail_o;
   logic [3:0] retry_cnt_o;
`ifdef LOCK_LOSS_COUNT_EN
   logic [7:0] lock_loss_cnt_o;
`endif

   god_bless_apollo_pll_reset_seq #(
      .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8),
      .STAGGER(3), .NUM_DOMAINS(2), .MAX_RETRIES(2)
   ) dut (
      .refclk(refclk), .rst(rst), .soft_rst_i(soft_rst_i), .pll_locked_i(pll_locked_i),
      .pll_rst_o(pll_rst_o), .dom_rst_o(dom_rst_o), .ready_o(ready_o),
      .fail_o(fail_o), .retry_cnt_o(retry_cnt_o)
`ifdef LOCK_LOSS_COUNT_EN
      , .lock_loss_cnt_o(lock_loss_cnt_o)
`endif
   );

   always #5 refclk = ~refclk;

   int edge_n = 0;
   always @(posedge refclk) edge_n <= edge_n + 1;

   typedef struct {
      int         cyc;
      logic [8:0] v;
      string      name;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   base;
   int   errors = 0;
   int   checks = 0;

   // {pll_rst, dom_rst[1:0], ready, fail, retry[3:0]}
   logic [8:0] obs;
   assign obs = {pll_rst_o, dom_rst_o, ready_o, fail_o, retry_cnt_o};

   task automatic push(input int k, input logic [8:0] v, input string nm);
      sb.push_back('{cyc: base + k, v: v, name: nm});
   endtask

   task automatic do_reset();
      @(negedge refclk);
      rst = 1'b1;
      soft_rst_i = 1'b0;
      repeat (3) @(negedge refclk);
      rst = 1'b0;
      base = edge_n;
   endtask

   task automatic test_clean_lock();
      pll_locked_i = 1'b0;
      do_reset();
      push(0,  9'b1_11_0_0_0000, "reset_state");
      push(3,  9'b1_11_0_0_0000, "pll_rst_c3");
      push(4,  9'b0_11_0_0_0000, "pll_rst_fall");
      push(15, 9'b0_11_0_0_0000, "dom_held_c15");
      push(16, 9'b0_10_0_0_0000, "dom0_release");
      push(18, 9'b0_10_0_0_0000, "dom1_held");
      push(19, 9'b0_00_0_0_0000, "dom1_release");
      push(20, 9'b0_00_1_0_0000, "ready_rise");
      for (int c = 0; c <= 22; c++) begin
         if (c > 0) @(negedge refclk);
         while (sb.size() > 0 && sb[0].cyc == edge_n) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
               errors++;
               $display("FAIL %s edge %0d: got %b want %b", e.name, edge_n - base, obs, e.v);
            end
         end
         if (c == 6) pll_locked_i = 1'b1;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL clean_lock_leftover: got %0d pending want 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_stable_glitch();
      pll_locked_i = 1'b0;
      do_reset();
      push(14, 9'b0_11_0_0_0000, "glitch_back_to_wait");
      push(21, 9'b0_11_0_0_0000, "glitch_dom_held");
      push(22, 9'b0_10_0_0_0000, "glitch_dom0_release");
      push(25, 9'b0_00_0_0_0000, "glitch_dom1_release");
      push(26, 9'b0_00_1_0_0000, "glitch_ready");
      for (int c = 0; c <= 27; c++) begin
         if (c > 0) @(negedge refclk);
         while (sb.size() > 0 && sb[0].cyc == edge_n) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
               errors++;
               $display("FAIL %s edge %0d: got %b want %b", e.name, edge_n - base, obs, e.v);
            end
         end
         if (c == 6)  pll_locked_i = 1'b1;
         if (c == 11) pll_locked_i = 1'b0;
         if (c == 12) pll_locked_i = 1'b1;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL glitch_leftover: got %0d pending want 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_run_lock_loss();
      base = edge_n;
      push(0, 9'b0_00_1_0_0000, "run_before_loss");
      push(2, 9'b0_00_1_0_0000, "run_sync_delay");
      push(3, 9'b1_11_0_0_0000, "loss_reassert");
      push(6, 9'b1_11_0_0_0000, "loss_pll_rst_c4");
      push(7, 9'b0_11_0_0_0000, "loss_pll_rst_fall");
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) @(negedge refclk);
         while (sb.size() > 0 && sb[0].cyc == edge_n) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
               errors++;
               $display("FAIL %s edge %0d: got %b want %b", e.name, edge_n - base, obs, e.v);
            end
         end
         if (c == 0) pll_locked_i = 1'b0;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL run_loss_leftover: got %0d pending want 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_never_locks();
      pll_locked_i = 1'b0;
      @(negedge refclk);
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== 9'b1_11_0_0_0000) begin
         errors++;
         $display("FAIL async_reset: got %b want %b", obs, 9'b1_11_0_0_0000);
      end
      repeat (2) @(negedge refclk);
      rst = 1'b0;
      base = edge_n;
      push(23,  9'b0_11_0_0_0000, "before_timeout1");
      push(24,  9'b1_11_0_0_0001, "timeout1_retry");
      push(27,  9'b1_11_0_0_0001, "retry_pll_rst_c4");
      push(28,  9'b0_11_0_0_0001, "retry_wait");
      push(47,  9'b0_11_0_0_0001, "before_timeout2");
      push(48,  9'b1_11_0_1_0010, "fail_entry");
      push(148, 9'b1_11_0_1_0010, "fail_hold_100");
      for (int c = 0; c <= 149; c++) begin
         if (c > 0) @(negedge refclk);
         while (sb.size() > 0 && sb[0].cyc == edge_n) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
               errors++;
               $display("FAIL %s edge %0d: got %b want %b", e.name, edge_n - base, obs, e.v);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL never_locks_leftover: got %0d pending want 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_soft_reset();
      base = edge_n;
      push(0,  9'b1_11_0_1_0010, "soft_pre_fail");
      push(1,  9'b1_11_0_0_0000, "soft_from_fail");
      push(5,  9'b0_11_0_0_0000, "soft_relock_wait");
      push(13, 9'b0_10_0_0_0000, "soft_release_dom0");
      push(14, 9'b0_10_0_0_0000, "soft_mid_release");
      push(15, 9'b1_11_0_0_0000, "soft_from_release");
      push(18, 9'b1_11_0_0_0000, "soft_pll_rst_held");
      for (int c = 0; c <= 19; c++) begin
         if (c > 0) @(negedge refclk);
         while (sb.size() > 0 && sb[0].cyc == edge_n) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
               errors++;
               $display("FAIL %s edge %0d: got %b want %b", e.name, edge_n - base, obs, e.v);
            end
         end
         if (c == 0)  soft_rst_i = 1'b1;
         if (c == 1)  begin soft_rst_i = 1'b0; pll_locked_i = 1'b1; end
         if (c == 14) soft_rst_i = 1'b1;
         if (c == 15) soft_rst_i = 1'b0;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL soft_leftover: got %0d pending want 0", sb.size());
      end
      sb.delete();
   endtask

`ifdef LOCK_LOSS_COUNT_EN
   task automatic test_lock_loss_count();
      pll_locked_i = 1'b1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         repeat (30) @(negedge refclk);
         checks++;
         if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL llc_ready_%0d: got %b want 1", i, ready_o);
         end
         pll_locked_i = 1'b0;
         repeat (10) @(negedge refclk);
         checks++;
         if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL llc_drop_%0d: got %b want 0", i, ready_o);
         end
         pll_locked_i = 1'b1;
      end
      checks++;
      if (lock_loss_cnt_o !== 8'd3) begin
         errors++;
         $display("FAIL llc_count: got %0d want 3", lock_loss_cnt_o);
      end
      soft_rst_i = 1'b1;
      @(negedge refclk);
      soft_rst_i = 1'b0;
      @(negedge refclk);
      checks++;
      if (lock_loss_cnt_o !== 8'd3) begin
         errors++;
         $display("FAIL llc_soft_keep: got %0d want 3", lock_loss_cnt_o);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (lock_loss_cnt_o !== 8'd0) begin
         errors++;
         $display("FAIL llc_rst_clear: got %0d want 0", lock_loss_cnt_o);
      end
      @(negedge refclk);
      rst = 1'b0;
   endtask
`endif

   initial begin
      test_clean_lock();
      test_stable_glitch();
      test_run_lock_loss();
      test_never_locks();
      test_soft_reset();
`ifdef LOCK_LOSS_COUNT_EN
      test_lock_loss_count();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
